// File: rtl/intr_ctrl_pkg.sv
// ============================================================================
// intr_ctrl_pkg : register map, ID layout and shared defaults for intr_ctrl
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

package intr_ctrl_pkg;

  localparam int DEFAULT_NSRC = 4;

  localparam int unsigned OFF_RAW     = 32'h00;
  localparam int unsigned OFF_ENABLE  = 32'h04;
  localparam int unsigned OFF_PENDING = 32'h08;
  localparam int unsigned OFF_MODE    = 32'h0C;
  localparam int unsigned OFF_ID      = 32'h10;
  localparam int unsigned OFF_SWSET   = 32'h14;

  localparam int ID_VALID_BIT = 31;

  typedef enum logic [2:0] {
    REG_RAW,
    REG_ENABLE,
    REG_PENDING,
    REG_MODE,
    REG_ID,
    REG_SWSET,
    REG_NONE
  } reg_sel_e;

  // Expects a word-aligned byte offset (low two bits already cleared).
  function automatic reg_sel_e decode_offset(input logic [31:0] off);
    case (off)
      OFF_RAW:     return REG_RAW;
      OFF_ENABLE:  return REG_ENABLE;
      OFF_PENDING: return REG_PENDING;
      OFF_MODE:    return REG_MODE;
      OFF_ID:      return REG_ID;
      OFF_SWSET:   return REG_SWSET;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/intr_sync_edge.sv
// ============================================================================
// intr_sync_edge : per-source 2-flop synchroniser plus delay flop, producing
//                  the synchronised level and a one-cycle assert event
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_sync_edge
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC = DEFAULT_NSRC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_n,
  output logic [NSRC-1:0] level,
  output logic [NSRC-1:0] assert_ev
);

  logic [NSRC-1:0] s1;
  logic [NSRC-1:0] s2;
  logic [NSRC-1:0] s3;
  logic [1:0]      fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '1;
      s2   <= '1;
      s3   <= '1;
      fill <= 2'd0;
    end else begin
      s1 <= src_n;
      s2 <= s1;
      s3 <= s2;
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
    end
  end

  // Events are suppressed until s3 holds a real sample, so a source held low
  // across reset is not mistaken for a fresh falling edge.
  assign level     = ~s2;
  assign assert_ev = (fill == 2'd3) ? (s3 & ~s2) : '0;

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
// intr_ctrl : memory-mapped interrupt controller - latches, masks and
//             prioritises peripheral requests onto a single active-low nIRQ
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC   = DEFAULT_NSRC,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CS_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  input  logic [NSRC-1:0]   IrqSrc_N,
  output logic              nIRQ
);

  logic [NSRC-1:0] level;
  logic [NSRC-1:0] assert_ev;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pending_next;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] wdata;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] swset;
  logic            wr_en;
  logic            rd_en;
  reg_sel_e        sel;
  logic            id_found;
  logic [4:0]      id_idx;
  logic [31:0]     id_word;
  logic            unused_bits;

  intr_sync_edge #(
    .NSRC (NSRC)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .src_n     (IrqSrc_N),
    .level     (level),
    .assert_ev (assert_ev)
  );

  assign wr_en = ~CS_N & ~WR_N;
  assign rd_en = ~CS_N & ~RD_N;
  assign sel   = decode_offset(32'({Addr[ADDR_W-1:2], 2'b00}));
  assign wdata = DataIn[NSRC-1:0];
  assign w1c   = (wr_en && sel == REG_PENDING) ? wdata : '0;
  assign swset = (wr_en && sel == REG_SWSET)   ? wdata : '0;

  assign unused_bits = ^{DataIn, Addr[1:0]};

  // Edge bits hold until cleared (set beats clear); level bits follow the pin.
  assign pending_next = (mode  & ((pending & ~w1c) | assert_ev | swset))
                      | (~mode & (level | swset));

  assign active = pending & enable;

  always_comb begin
    id_found = 1'b0;
    id_idx   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_found = 1'b1;
        id_idx   = 5'(i);
      end
    end
  end

  always_comb begin
    id_word               = '0;
    id_word[ID_VALID_BIT] = id_found;
    id_word[4:0]          = id_idx;
  end

  always_comb begin
    DataOut = '0;
    if (rd_en) begin
      case (sel)
        REG_RAW:     DataOut = 32'(level);
        REG_ENABLE:  DataOut = 32'(enable);
        REG_PENDING: DataOut = 32'(pending);
        REG_MODE:    DataOut = 32'(mode);
        REG_ID:      DataOut = id_word;
        default:     DataOut = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= '0;
      pending <= '0;
      mode    <= '0;
      nIRQ    <= 1'b1;
    end else begin
      pending <= pending_next;
      nIRQ    <= ~|active;
      if (wr_en && sel == REG_ENABLE) begin
        enable <= wdata;
      end
      if (wr_en && sel == REG_MODE) begin
        mode <= wdata;
      end
    end
  end

endmodule

`default_nettype wire
